pcl_branch: RTL and testbench
=============================

# pcl_branch

Program Counter Low stage of the 6502 core: PCL select (PCLS), increment logic, the PCL register, and a taken-branch fix-up sequencer. It sits directly upstream of the Program Counter High stage. Its `o_pclc` drives the PCH carry input `i_pclc`, and it flags backward page crossings to the control logic. Like PCH, it passes through during phi2 (`i_clk` high) and latches on the falling edge of `i_clk`.

## Interface
Parameters: none.

Ports:
- `i_clk`  in  1  phi2 clock; single clock domain.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_pcl_pcl`  in  1  control: PCLS takes the current PCL.
- `i_adl_pcl`  in  1  control: PCLS takes ADL.
- `i_adl`  in  8  ADL bus.
- `i_i_pc`  in  1  control: increment PCLS by 1.
- `i_branch`  in  1  taken-branch request, sampled at the falling edge.
- `i_offset`  in  8  signed two's-complement branch offset, sampled with `i_branch`.
- `o_pcl`  out  8  program counter low.
- `o_pclc`  out  1  carry to PCH `i_pclc`.
- `o_pch_borrow`  out  1  backward page crossing; control must decrement PCH this cycle.
- `o_busy`  out  1  branch sequence in progress.

## Operation
- Registers: `r_pcl[7:0]`, `r_off[7:0]`, `r_fwd` (1 bit), and a state register with states IDLE, ADD and FIX.
- PCLS priority (IDLE only), in order:
  - `i_pcl_pcl` selects `r_pcl`.
  - Otherwise `i_adl_pcl` selects `i_adl`.
  - Otherwise 8'h00.
- Next PCL value in IDLE is `pcls + i_i_pc`, truncated to 8 bits. `o_pclc = i_i_pc & (pcls == 8'hFF)`.
- IDLE with `i_branch` = 1 at the falling edge:
  - The IDLE next value still latches into `r_pcl` on that edge.
  - `r_off <= i_offset`.
  - State goes to ADD.
- ADD:
  - Selects and `i_i_pc` are ignored.
  - 9-bit sum `{c, s} = r_pcl + r_off`, with the offset treated as unsigned; next value is `s`.
  - Forward crossing: `!r_off[7] & c`. Backward crossing: `r_off[7] & !c`.
  - If either crossing occurs, the state goes to FIX and `r_fwd <= !r_off[7]`. Otherwise it goes to IDLE.
  - `o_pclc = 0`.
- FIX:
  - `r_pcl` holds.
  - `o_pclc = r_fwd` and `o_pch_borrow = !r_fwd`.
  - Next state is IDLE.
  - For a forward crossing, control asserts PCH `i_pch_pch` so PCH increments.
- `o_busy` = 1 in ADD and FIX. `i_branch` is ignored while busy.
- `o_pch_borrow` = 0 outside FIX.

## Timing
- One cycle is one `i_clk` period. All registers update on the falling edge of `i_clk`.
- `o_pcl` is the next value while `i_clk` = 1 (transparent) and `r_pcl` while `i_clk` = 0.
- `o_pclc` and `o_pch_borrow` are combinational. They are valid during phi2, when PCH samples them.
- Branch latency from the `i_branch` edge:
  - No crossing: 1 cycle (ADD only).
  - Crossing: 2 cycles (ADD then FIX).
- Wrap-around:
  - FF + 1 gives 00 with `o_pclc` = 1.
  - Branch sums wrap modulo 256; the crossing flags carry the page information.
- Simultaneous events:
  - In IDLE, `i_branch` with `i_i_pc`: the increment applies on that edge, and the branch then adds to the incremented value.
  - `i_pcl_pcl` with `i_adl_pcl`: `i_pcl_pcl` wins.
- Reset, asynchronous and active at any time, including mid-sequence:
  - `r_pcl`, `r_off` and `r_fwd` go to 0; state goes to IDLE.
  - `o_pcl`, `o_pclc`, `o_pch_borrow` and `o_busy` are 0 regardless of `i_clk`.
  - Normal operation resumes on the first falling edge after release.

## Configuration
- Macro: `PCL_BRANCH_FIXUP_EN`.
- Defined: the ADD/FIX sequencer, `r_off` and `r_fwd` are compiled in, as described above.
- Undefined:
  - The state is permanently IDLE, and `i_branch` and `i_offset` are ignored.
  - `o_busy` and `o_pch_borrow` are tied to 0.
  - `o_pclc` comes from the increment only.
  - Branch targets are then computed by the ALU and loaded via ADL.

## Test plan
- Reset asserted while `i_clk` is high and mid-FIX → all outputs 0 immediately; after release, state is IDLE and `o_pcl` = 00.
- Load 8'h3C via ADL, then 3 cycles with `i_pcl_pcl` = 1 and `i_i_pc` = 1 → latched `o_pcl` 3D, 3E, 3F; `o_pclc` = 0 throughout.
- PCL = FF, `i_pcl_pcl` = 1, `i_i_pc` = 1 → `o_pclc` = 1 during phi2, latched `o_pcl` = 00, and PCH increments.
- PCL = 10, branch with offset 8'h05 → ADD latches 15; `o_busy` high for 1 cycle; `o_pclc` = 0 and `o_pch_borrow` = 0.
- PCL = F0, branch with offset 8'h20 → ADD latches 10, then FIX with `o_pclc` = 1 for one cycle. PCL = 05, branch with offset 8'hF0 → ADD latches F5, then FIX with `o_pch_borrow` = 1.
- `PCL_BRANCH_FIXUP_EN` undefined, branch with offset 8'h20 → `o_pcl` follows the selects and increment only; `o_busy` and `o_pch_borrow` stay 0.

Source files
------------

// File: rtl/pcl_branch_if.sv
// 6502 PCL stage bus: PC-low select/increment controls, branch request, PCL outputs to PCH/control.
// Pure wiring; the slave modport is the PCL stage, the master modport is the control/PCH side.
interface pcl_branch_if;
  logic       i_pcl_pcl;
  logic       i_adl_pcl;
  logic [7:0] i_adl;
  logic       i_i_pc;
  logic       i_branch;
  logic [7:0] i_offset;
  logic [7:0] o_pcl;
  logic       o_pclc;
  logic       o_pch_borrow;
  logic       o_busy;

  modport slave (
    input  i_pcl_pcl, i_adl_pcl, i_adl, i_i_pc, i_branch, i_offset,
    output o_pcl, o_pclc, o_pch_borrow, o_busy
  );

  modport master (
    output i_pcl_pcl, i_adl_pcl, i_adl, i_i_pc, i_branch, i_offset,
    input  o_pcl, o_pclc, o_pch_borrow, o_busy
  );
endinterface

// File: rtl/pcl_branch.sv
// PCL select/increment/register with taken-branch ADD/FIX sequencer (compiled in by PCL_BRANCH_FIXUP_EN).
// Latency: PCL transparent in phi2, latched on falling i_clk; branch takes 1 cycle, 2 on page cross.
// Backpressure: none; o_busy flags the branch sequence, during which selects and i_branch are ignored.
module pcl_branch (
  input  logic          i_clk,
  input  logic          i_reset_n,
  pcl_branch_if.slave   bus
);

  logic [7:0] r_pcl;
  logic [7:0] pcls;
  logic [7:0] inc_sum;
  logic       inc_c;
  logic [7:0] pcl_nxt;
  logic       pclc;
  logic       borrow;
  logic       busy;

  always_comb begin
    pcls = 8'h00;
    if (bus.i_pcl_pcl)
      pcls = r_pcl;
    else if (bus.i_adl_pcl)
      pcls = bus.i_adl;
  end

  // Carry out of the increment is exactly i_i_pc & (pcls == 8'hFF).
  assign {inc_c, inc_sum} = {1'b0, pcls} + {8'h00, bus.i_i_pc};

`ifdef PCL_BRANCH_FIXUP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] r_off;
  logic       r_fwd;
  logic [8:0] br_sum;
  logic       cross;

  assign br_sum = {1'b0, r_pcl} + {1'b0, r_off};
  // Forward (!off[7] & c) or backward (off[7] & !c) page crossing.
  assign cross  = r_off[7] ^ br_sum[8];

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      r_off <= 8'h00;
      r_fwd <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.i_branch)
        r_off <= bus.i_offset;
      if (state == ADD && cross)
        r_fwd <= !r_off[7];
    end
  end

  always_comb begin
    state_nxt = state;
    pcl_nxt   = inc_sum;
    pclc      = inc_c;
    borrow    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_branch)
          state_nxt = ADD;
      end
      ADD: begin
        pcl_nxt   = br_sum[7:0];
        pclc      = 1'b0;
        busy      = 1'b1;
        state_nxt = cross ? FIX : IDLE;
      end
      FIX: begin
        pcl_nxt   = r_pcl;
        pclc      = r_fwd;
        borrow    = !r_fwd;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic unused_branch;
  assign unused_branch = &{1'b0, bus.i_branch, bus.i_offset};

  assign pcl_nxt = inc_sum;
  assign pclc    = inc_c;
  assign borrow  = 1'b0;
  assign busy    = 1'b0;
`endif

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_pcl <= 8'h00;
    else
      r_pcl <= pcl_nxt;
  end

  // Transparent in phi2, held in phi1; forced low throughout reset.
  assign bus.o_pcl        = !i_reset_n ? 8'h00 : (i_clk ? pcl_nxt : r_pcl);
  assign bus.o_pclc       = i_reset_n & pclc;
  assign bus.o_pch_borrow = i_reset_n & borrow;
  assign bus.o_busy       = i_reset_n & busy;

endmodule

// File: tb/tb_pcl_branch.sv
// Table-driven bench for pcl_branch with an expected-result queue; covers both builds of PCL_BRANCH_FIXUP_EN.
module tb_pcl_branch;
  logic i_clk;
  logic i_reset_n;

  pcl_branch_if bus ();

  pcl_branch dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       pcl_pcl;
    logic       adl_pcl;
    logic [7:0] adl;
    logic       i_pc;
    logic       branch;
    logic [7:0] offset;
    logic [7:0] e_phi;
    logic       e_pclc;
    logic       e_bor;
    logic       e_busy;
    logic [7:0] e_pcl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t v(input logic pp, input logic ap, input logic [7:0] adl,
                             input logic ipc, input logic br, input logic [7:0] off,
                             input logic [7:0] ephi, input logic epclc, input logic ebor,
                             input logic ebusy, input logic [7:0] epcl);
    vec_t r;
    r.pcl_pcl = pp; r.adl_pcl = ap; r.adl = adl; r.i_pc = ipc;
    r.branch = br; r.offset = off; r.e_phi = ephi; r.e_pclc = epclc;
    r.e_bor = ebor; r.e_busy = ebusy; r.e_pcl = epcl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.i_pcl_pcl = x.pcl_pcl;
    bus.i_adl_pcl = x.adl_pcl;
    bus.i_adl     = x.adl;
    bus.i_i_pc    = x.i_pc;
    bus.i_branch  = x.branch;
    bus.i_offset  = x.offset;
  endtask

  // Called with i_clk low; returns 1 time unit after the next falling edge.
  task automatic run_vec(input vec_t x, input string tag);
    vec_t e;
    drive(x);
    sb.push_back(x);
    @(posedge i_clk);
    #2;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s_sb: expected queue empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_phi2_pcl"}, bus.o_pcl, e.e_phi);
      chk({tag, "_pclc"}, {7'd0, bus.o_pclc}, {7'd0, e.e_pclc});
      chk({tag, "_borrow"}, {7'd0, bus.o_pch_borrow}, {7'd0, e.e_bor});
      chk({tag, "_busy"}, {7'd0, bus.o_busy}, {7'd0, e.e_busy});
      @(negedge i_clk);
      #1;
      chk({tag, "_latched_pcl"}, bus.o_pcl, e.e_pcl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0;
    drive(v(0, 1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 0, 0));

    // Reset state, both clock phases, with an ADL select that must not leak out.
    @(posedge i_clk);
    #2;
    chk("rst_phi2_pcl", bus.o_pcl, 8'h00);
    chk("rst_phi2_pclc", {7'd0, bus.o_pclc}, 8'h00);
    chk("rst_phi2_busy", {7'd0, bus.o_busy}, 8'h00);
    chk("rst_phi2_borrow", {7'd0, bus.o_pch_borrow}, 8'h00);
    @(negedge i_clk);
    #1;
    chk("rst_phi1_pcl", bus.o_pcl, 8'h00);
    drive(v(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    i_reset_n = 1'b1;

    // Common select/increment part.
    vecs.push_back(v(0, 1, 8'h3C, 0, 0, 8'h00, 8'h3C, 0, 0, 0, 8'h3C));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 8'h3D, 0, 0, 0, 8'h3D));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 8'h3E, 0, 0, 0, 8'h3E));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 8'h3F, 0, 0, 0, 8'h3F));
    vecs.push_back(v(1, 1, 8'h55, 0, 0, 8'h00, 8'h3F, 0, 0, 0, 8'h3F));
    vecs.push_back(v(0, 0, 8'h77, 1, 0, 8'h00, 8'h01, 0, 0, 0, 8'h01));
    vecs.push_back(v(0, 1, 8'hFF, 0, 0, 8'h00, 8'hFF, 0, 0, 0, 8'hFF));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00));
    vecs.push_back(v(0, 1, 8'hFF, 1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00));
`ifdef PCL_BRANCH_FIXUP_EN
    // No crossing: 10 + 05; branch during ADD is ignored.
    vecs.push_back(v(0, 1, 8'h10, 0, 1, 8'h05, 8'h10, 0, 0, 0, 8'h10));
    vecs.push_back(v(0, 1, 8'hAA, 1, 1, 8'h7F, 8'h15, 0, 0, 1, 8'h15));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'h15, 0, 0, 0, 8'h15));
    // Forward crossing: F0 + 20.
    vecs.push_back(v(0, 1, 8'hF0, 0, 1, 8'h20, 8'hF0, 0, 0, 0, 8'hF0));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 8'h10, 0, 0, 1, 8'h10));
    vecs.push_back(v(0, 1, 8'h33, 1, 0, 8'h00, 8'h10, 1, 0, 1, 8'h10));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'h10, 0, 0, 0, 8'h10));
    // Backward crossing: 05 + F0.
    vecs.push_back(v(0, 1, 8'h05, 0, 1, 8'hF0, 8'h05, 0, 0, 0, 8'h05));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'hF5, 0, 0, 1, 8'hF5));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'hF5, 0, 1, 1, 8'hF5));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'hF5, 0, 0, 0, 8'hF5));
    // Increment with branch, then backward offset that stays in page.
    vecs.push_back(v(1, 0, 8'h00, 1, 1, 8'h02, 8'hF6, 0, 0, 0, 8'hF6));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'hF8, 0, 0, 1, 8'hF8));
    vecs.push_back(v(1, 0, 8'h00, 0, 1, 8'hFE, 8'hF8, 0, 0, 0, 8'hF8));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'hF6, 0, 0, 1, 8'hF6));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'hF6, 0, 0, 0, 8'hF6));
`else
    // Branch requests have no effect; only selects and increment count.
    vecs.push_back(v(0, 1, 8'h10, 0, 1, 8'h05, 8'h10, 0, 0, 0, 8'h10));
    vecs.push_back(v(0, 1, 8'hAA, 1, 1, 8'h7F, 8'hAB, 0, 0, 0, 8'hAB));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'hAB, 0, 0, 0, 8'hAB));
    vecs.push_back(v(0, 1, 8'hF0, 0, 1, 8'h20, 8'hF0, 0, 0, 0, 8'hF0));
    vecs.push_back(v(1, 0, 8'h00, 1, 0, 8'h00, 8'hF1, 0, 0, 0, 8'hF1));
    vecs.push_back(v(0, 1, 8'h33, 1, 0, 8'h00, 8'h34, 0, 0, 0, 8'h34));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'h34, 0, 0, 0, 8'h34));
    vecs.push_back(v(0, 1, 8'h05, 0, 1, 8'hF0, 8'h05, 0, 0, 0, 8'h05));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'h05, 0, 0, 0, 8'h05));
    vecs.push_back(v(1, 0, 8'h00, 1, 1, 8'h02, 8'h06, 0, 0, 0, 8'h06));
    vecs.push_back(v(1, 0, 8'h00, 0, 0, 8'h00, 8'h06, 0, 0, 0, 8'h06));
`endif

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("row%0d", i));

    // Reset asserted in phi2 in the middle of a branch sequence (FIX when enabled).
    run_vec(v(0, 1, 8'hF0, 0, 1, 8'h20, 8'hF0, 0, 0, 0, 8'hF0), "mid_a");
`ifdef PCL_BRANCH_FIXUP_EN
    run_vec(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h10, 0, 0, 1, 8'h10), "mid_b");
`else
    run_vec(v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00), "mid_b");
`endif
    drive(v(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0));
    @(posedge i_clk);
    #2;
`ifdef PCL_BRANCH_FIXUP_EN
    chk("mid_fix_pclc", {7'd0, bus.o_pclc}, 8'h01);
    chk("mid_fix_busy", {7'd0, bus.o_busy}, 8'h01);
`else
    chk("mid_inc_pcl", bus.o_pcl, 8'h01);
`endif
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_pcl", bus.o_pcl, 8'h00);
    chk("mid_rst_pclc", {7'd0, bus.o_pclc}, 8'h00);
    chk("mid_rst_borrow", {7'd0, bus.o_pch_borrow}, 8'h00);
    chk("mid_rst_busy", {7'd0, bus.o_busy}, 8'h00);
    @(negedge i_clk);
    #1;
    chk("mid_rst_phi1_pcl", bus.o_pcl, 8'h00);
    i_reset_n = 1'b1;
    run_vec(v(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00), "post_rst");
    run_vec(v(1, 0, 8'h00, 1, 0, 8'h00, 8'h01, 0, 0, 0, 8'h01), "post_rst_inc");

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
